// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC sequencing controller.
package mac_pkg;

  localparam int unsigned MacDataW = 32;
  localparam int unsigned MacAddrW = 10;
  localparam int unsigned MacLenW  = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StCapt,
    StOut,
    StFin
  } mac_state_e;

endpackage

// File: rtl/mac_addr_gen.sv
// Element/vector counters and ifmap/weight address generation for one MAC job.
module mac_addr_gen
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_W = MacAddrW,
  parameter int unsigned LEN_W  = MacLenW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              next_vec_i,
  input  logic [LEN_W-1:0]  vec_len_i,
  input  logic [LEN_W-1:0]  num_vec_i,
  input  logic [ADDR_W-1:0] if_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  output logic [ADDR_W-1:0] if_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic              last_k_o,
  output logic              last_v_o
);

  logic [LEN_W-1:0]  vec_len_q, vec_len_d;
  logic [LEN_W-1:0]  num_vec_q, num_vec_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  v_q, v_d;
  logic [ADDR_W-1:0] if_base_q, if_base_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;

  assign last_k_o  = (k_q == vec_len_q - LEN_W'(1));
  assign last_v_o  = (v_q == num_vec_q - LEN_W'(1));
  assign if_addr_o = if_addr_q;
  assign w_addr_o  = w_addr_q;

  always_comb begin
    vec_len_d = vec_len_q;
    num_vec_d = num_vec_q;
    k_d       = k_q;
    v_d       = v_q;
    if_base_d = if_base_q;
    row_d     = row_q;
    if_addr_d = if_addr_q;
    w_addr_d  = w_addr_q;
    if (load_i) begin
      vec_len_d = vec_len_i;
      num_vec_d = num_vec_i;
      if_base_d = if_base_i;
      k_d       = '0;
      v_d       = '0;
      row_d     = w_base_i;
      if_addr_d = if_base_i;
      w_addr_d  = w_base_i;
    end else if (step_i && !last_k_o) begin
      k_d       = k_q + LEN_W'(1);
      if_addr_d = if_addr_q + ADDR_W'(1);
      w_addr_d  = w_addr_q + ADDR_W'(1);
    end else if (next_vec_i) begin
      // Weight rows are packed back to back, so each vector starts vec_len further on.
      k_d       = '0;
      v_d       = v_q + LEN_W'(1);
      row_d     = row_q + ADDR_W'(vec_len_q);
      if_addr_d = if_base_q;
      w_addr_d  = row_q + ADDR_W'(vec_len_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_len_q <= '0;
      num_vec_q <= '0;
      k_q       <= '0;
      v_q       <= '0;
      if_base_q <= '0;
      row_q     <= '0;
      if_addr_q <= '0;
      w_addr_q  <= '0;
    end else begin
      vec_len_q <= vec_len_d;
      num_vec_q <= num_vec_d;
      k_q       <= k_d;
      v_q       <= v_d;
      if_base_q <= if_base_d;
      row_q     <= row_d;
      if_addr_q <= if_addr_d;
      w_addr_q  <= w_addr_d;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer that streams buffer reads into a MAC and hands each dot product out.
// Optional stall counter output enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MacDataW,
  parameter int unsigned ADDR_W = MacAddrW,
  parameter int unsigned LEN_W  = MacLenW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [LEN_W-1:0]  num_vec,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              rd_en,
  output logic              mac_en,
  output logic              mac_lastdata,
  input  logic [DATA_W-1:0] mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef MAC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  mac_state_e        state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic              mac_en_q, mac_en_d;
  logic              mac_last_q, mac_last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, step, next_vec;
  logic              last_k, last_v;

  mac_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (load),
    .step_i    (step),
    .next_vec_i(next_vec),
    .vec_len_i (vec_len),
    .num_vec_i (num_vec),
    .if_base_i (if_base),
    .w_base_i  (w_base),
    .if_addr_o (if_addr),
    .w_addr_o  (w_addr),
    .last_k_o  (last_k),
    .last_v_o  (last_v)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    next_vec   = 1'b0;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((vec_len != '0) && (num_vec != '0)) begin
            state_d = StRun;
            load    = 1'b1;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        step = 1'b1;
        if (last_k) state_d = StDrain;
      end
      StDrain: state_d = StCapt;
      StCapt: begin
        out_data_d = mac_acc;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (last_v) begin
            state_d = StFin;
          end else begin
            state_d  = StRun;
            next_vec = 1'b1;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered: they reflect the state being entered.
    rd_en_d     = (state_d == StRun);
    mac_en_d    = rd_en_q;
    mac_last_d  = rd_en_q && last_k;
    out_valid_d = (state_d == StOut);
    busy_d      = (state_d inside {StRun, StDrain, StCapt, StOut});
    done_d      = (state_d == StFin);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_en_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      mac_en_q    <= mac_en_d;
      mac_last_q  <= mac_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign mac_en       = mac_en_q;
  assign mac_lastdata = mac_last_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && start) begin
      stall_d = '0;
    end else if ((state_q == StOut) && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl with a behavioural buffer/MAC model.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  vec_len, num_vec, if_base, w_base;
  logic [9:0]  if_addr, w_addr;
  logic        rd_en, mac_en, mac_lastdata;
  logic [31:0] mac_acc;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        busy, done;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .vec_len     (vec_len),
    .num_vec     (num_vec),
    .if_base     (if_base),
    .w_base      (w_base),
    .if_addr     (if_addr),
    .w_addr      (w_addr),
    .rd_en       (rd_en),
    .mac_en      (mac_en),
    .mac_lastdata(mac_lastdata),
    .mac_acc     (mac_acc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Buffers hold ifmap[a] = a + 1 and weight[a] = a + 2; the MAC restarts after each last element.
  logic [31:0] rd_if_q, rd_w_q, acc_q;
  logic        fresh_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_if_q <= 32'd0;
      rd_w_q  <= 32'd0;
      acc_q   <= 32'd0;
      fresh_q <= 1'b1;
    end else begin
      if (rd_en) begin
        rd_if_q <= 32'(if_addr) + 32'd1;
        rd_w_q  <= 32'(w_addr) + 32'd2;
      end
      if (mac_en) begin
        acc_q   <= (fresh_q ? 32'd0 : acc_q) + rd_if_q * rd_w_q;
        fresh_q <= mac_lastdata;
      end
    end
  end
  assign mac_acc = acc_q;

  int ifq[$], wq[$], lastq[$], resq[$];
  int mac_cnt, ov_cnt, done_cnt, viol_cnt;
  always @(negedge clk) begin
    if (rd_en) begin
      ifq.push_back(int'(32'(if_addr)));
      wq.push_back(int'(32'(w_addr)));
    end
    if (mac_en) begin
      mac_cnt++;
      if (mac_lastdata) lastq.push_back(mac_cnt);
    end
    if (out_valid) ov_cnt++;
    if (out_valid && out_ready) resq.push_back(int'(out_data));
    if (done) done_cnt++;
    if (out_valid && (rd_en || mac_en)) viol_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expects n*reps entries of the form (start + i mod n) mod 1024.
  task automatic check_seq(input string tag, input int got[$], input int st, input int n,
                           input int reps);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(n * reps));
    for (int i = 0; i < n * reps; i++) begin
      if (i < got.size())
        check_eq($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'((st + (i % n)) % 1024));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    ifq.delete();
    wq.delete();
    lastq.delete();
    resq.delete();
    mac_cnt  = 0;
    ov_cnt   = 0;
    done_cnt = 0;
    viol_cnt = 0;
  endtask

  task automatic start_job(input int vl, input int nv, input int ib, input int wb);
    vec_len = 10'(vl);
    num_vec = 10'(nv);
    if_base = 10'(ib);
    w_base  = 10'(wb);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    check_eq("valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mac_before;
    logic [31:0] held;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    vec_len = '0; num_vec = '0; if_base = '0; w_base = '0;
    clr_mon();
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_if_addr", 32'(if_addr), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Single vector, no backpressure.
    clr_mon();
    start_job(4, 1, 0, 16);
    check_eq("s1_rd_en", 32'(rd_en), 32'd1);
    check_eq("s1_busy", 32'(busy), 32'd1);
    check_eq("s1_if0", 32'(if_addr), 32'd0);
    check_eq("s1_w0", 32'(w_addr), 32'd16);
    wait_valid(20, n);
    check_eq("s1_latency", 32'(n), 32'd6);
    check_eq("s1_data", out_data, 32'd200);
    tick();
    check_eq("s1_done", 32'(done), 32'd1);
    check_eq("s1_busy_fin", 32'(busy), 32'd0);
    tick();
    check_eq("s1_done_clr", 32'(done), 32'd0);
    check_seq("s1_if", ifq, 0, 4, 1);
    check_seq("s1_w", wq, 16, 4, 1);
    check_eq("s1_mac_cnt", 32'(mac_cnt), 32'd4);
    check_eq("s1_last_n", 32'(lastq.size()), 32'd1);
    if (lastq.size() > 0) check_eq("s1_last_pos", 32'(lastq[0]), 32'd4);

    // Two vectors, with a start pulse and changed inputs mid-job that must be ignored.
    clr_mon();
    start_job(3, 2, 0, 8);
    tick();
    start = 1'b1; vec_len = 10'd7; if_base = 10'd100;
    tick();
    start = 1'b0;
    wait_done(40);
    tick();
    check_seq("s2_if", ifq, 0, 3, 2);
    check_seq("s2_w", wq, 8, 6, 1);
    check_eq("s2_res_n", 32'(resq.size()), 32'd2);
    if (resq.size() >= 2) begin
      check_eq("s2_res0", 32'(resq[0]), 32'd68);
      check_eq("s2_res1", 32'(resq[1]), 32'd86);
    end
    check_eq("s2_last_n", 32'(lastq.size()), 32'd2);
    if (lastq.size() >= 2) begin
      check_eq("s2_last0", 32'(lastq[0]), 32'd3);
      check_eq("s2_last1", 32'(lastq[1]), 32'd6);
    end
    check_eq("s2_done_cnt", 32'(done_cnt), 32'd1);

    // Zero-length jobs finish immediately.
    clr_mon();
    start_job(0, 3, 0, 0);
    check_eq("s3_done", 32'(done), 32'd1);
    check_eq("s3_busy", 32'(busy), 32'd0);
    tick();
    check_eq("s3_done_clr", 32'(done), 32'd0);
    start_job(2, 0, 0, 0);
    check_eq("s3b_done", 32'(done), 32'd1);
    tick();
    check_eq("s3_mac_cnt", 32'(mac_cnt), 32'd0);
    check_eq("s3_ov_cnt", 32'(ov_cnt), 32'd0);
    check_eq("s3_rd_cnt", 32'(ifq.size()), 32'd0);

    // Backpressure: out_ready low for five cycles in OUT.
    clr_mon();
    out_ready = 1'b0;
    start_job(2, 1, 5, 20);
    wait_valid(20, n);
    check_eq("s4_latency", 32'(n), 32'd4);
    held = out_data;
    check_eq("s4_data", held, 32'd293);
    for (int i = 0; i < 5; i++) begin
      check_eq("s4_valid_hold", 32'(out_valid), 32'd1);
      check_eq("s4_data_hold", out_data, held);
      check_eq("s4_no_rd", 32'(rd_en), 32'd0);
      tick();
    end
`ifdef MAC_SEQ_PERF_CNT_EN
    check_eq("s4_stall_cnt", stall_cnt, 32'd5);
`endif
    out_ready = 1'b1;
    tick();
    check_eq("s4_done", 32'(done), 32'd1);
    tick();
    check_eq("s4_res_n", 32'(resq.size()), 32'd1);
    if (resq.size() > 0) check_eq("s4_res", 32'(resq[0]), 32'd293);
    check_eq("s4_viol", 32'(viol_cnt), 32'd0);

    // Reset mid-job, then a clean job.
    clr_mon();
    start_job(4, 1, 0, 0);
    tick();
    tick();
    check_eq("s5_k2", 32'(if_addr), 32'd2);
    reset = 1'b0;
    #1;
    check_eq("s5_rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("s5_rst_if", 32'(if_addr), 32'd0);
    check_eq("s5_rst_busy", 32'(busy), 32'd0);
    check_eq("s5_rst_mac_en", 32'(mac_en), 32'd0);
    check_eq("s5_rst_out_data", out_data, 32'd0);
    mac_before = mac_cnt;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_eq("s5_no_mac", 32'(mac_cnt), 32'(mac_before));
    check_eq("s5_idle_busy", 32'(busy), 32'd0);
    clr_mon();
    start_job(2, 1, 3, 7);
    wait_done(20);
    tick();
    check_seq("s5_if", ifq, 3, 2, 1);
    check_seq("s5_w", wq, 7, 2, 1);
    check_eq("s5_res_n", 32'(resq.size()), 32'd1);
    if (resq.size() > 0) check_eq("s5_res", 32'(resq[0]), 32'd86);

    // Address wrap at the top of the 10-bit space.
    clr_mon();
    start_job(4, 1, 1022, 1020);
    wait_done(30);
    tick();
    check_seq("s6_if", ifq, 1022, 4, 1);
    check_seq("s6_w", wq, 1020, 4, 1);
    check_eq("s6_res_n", 32'(resq.size()), 32'd1);
    if (resq.size() > 0) check_eq("s6_res", 32'(resq[0]), 32'd2096132);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
